// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic light timer and its controller bench:
//   - default interval / debounce lengths and counter width
//   - debouncer FSM state encoding
// -----------------------------------------------------------------------------
package traffic_pkg;

    localparam int DEF_TS_CYCLES  = 5;
    localparam int DEF_TL_CYCLES  = 15;
    localparam int DEF_DEB_CYCLES = 4;
    localparam int DEF_CNT_W      = 16;

    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } deb_state_t;

endpackage

// File: rtl/car_debounce.sv
// -----------------------------------------------------------------------------
// car_debounce
// Synchronizes the raw, bouncing side-road car sensor into the Clk domain and
// debounces it. C only changes after the synchronized sensor has disagreed
// with C for DEB_CYCLES+1 consecutive samples. Any agreeing sample in between
// restarts the wait.
//
// Ports:
//   Clk     in   system clock, rising edge
//   reset   in   asynchronous, active-high reset
//   CAR_IN  in   raw car sensor (asynchronous to Clk)
//   C       out  debounced car-present, registered
// -----------------------------------------------------------------------------
module car_debounce
    import traffic_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic Clk,
    input  logic reset,
    input  logic CAR_IN,
    output logic C
);

    localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEB_CYCLES);

    logic             sync_q1;
    logic             car_s;
    deb_state_t       state;
    deb_state_t       state_next;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] deb_cnt_next;
    logic             c_next;

    // Two-flop synchronizer: sync_q1 may go metastable, car_s is safe to use.
    // NOTE: clocked blocks use non-blocking assignments so every flop samples
    // the pre-edge value of the others; blocking here would collapse the chain.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            sync_q1 <= 1'b0;
            car_s   <= 1'b0;
        end else begin
            sync_q1 <= CAR_IN;
            car_s   <= sync_q1;
        end
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state   <= STABLE;
            deb_cnt <= '0;
            C       <= 1'b0;
        end else begin
            state   <= state_next;
            deb_cnt <= deb_cnt_next;
            C       <= c_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        deb_cnt_next = '0;
        c_next       = C;
        case (state)
            STABLE: begin
                if (car_s != C) begin
                    state_next   = PENDING;
                    deb_cnt_next = CNT_W'(1);
                end
            end
            PENDING: begin
                if (car_s == C) begin
                    // Glitch shorter than the debounce window: drop it.
                    state_next = STABLE;
                end else if (deb_cnt == DEB_LIMIT) begin
                    c_next     = ~C;
                    state_next = STABLE;
                end else begin
                    deb_cnt_next = deb_cnt + CNT_W'(1);
                end
            end
            default: state_next = STABLE;
        endcase
    end

endmodule

// File: rtl/traffic_timer.sv
// -----------------------------------------------------------------------------
// traffic_timer
// Interval timer and car sensor conditioning for a traffic light controller.
// ST restarts the interval count; TS and TL flag that the short and long
// intervals have elapsed since the last ST and hold until the next one.
// The count saturates at TL_CYCLES so the flags never fall back on wrap.
// All outputs are registered; no input reaches an output combinationally.
//
// Ports:
//   Clk     in   system clock, rising edge
//   reset   in   asynchronous, active-high reset
//   ST      in   start timer (synchronous to Clk)
//   CAR_IN  in   raw side-road car sensor (asynchronous, bouncing)
//   TS      out  short interval elapsed since last ST
//   TL      out  long interval elapsed since last ST
//   C       out  debounced car-present
// -----------------------------------------------------------------------------
module traffic_timer
    import traffic_pkg::*;
#(
    parameter int TS_CYCLES  = DEF_TS_CYCLES,
    parameter int TL_CYCLES  = DEF_TL_CYCLES,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic Clk,
    input  logic reset,
    input  logic ST,
    input  logic CAR_IN,
    output logic TS,
    output logic TL,
    output logic C
);

    localparam logic [CNT_W-1:0] TS_LIMIT = CNT_W'(TS_CYCLES);
    localparam logic [CNT_W-1:0] TL_LIMIT = CNT_W'(TL_CYCLES);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    // ST wins over everything, including the edge where a flag would rise.
    always_comb begin
        if (ST) begin
            count_next = '0;
        end else if (count >= TL_LIMIT) begin
            count_next = count;
        end else begin
            count_next = count + CNT_W'(1);
        end
    end

    // Flags are derived from count_next so they line up with the count
    // itself: TS reads 1 exactly TS_CYCLES edges after the ST edge.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            TS    <= 1'b0;
            TL    <= 1'b0;
        end else begin
            count <= count_next;
            TS    <= (count_next >= TS_LIMIT);
            TL    <= (count_next >= TL_LIMIT);
        end
    end

    car_debounce #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_car_debounce (
        .Clk    (Clk),
        .reset  (reset),
        .CAR_IN (CAR_IN),
        .C      (C)
    );

endmodule

// File: tb/tb_traffic_timer.sv
// -----------------------------------------------------------------------------
// tb_traffic_timer
// Directed stimulus for traffic_timer with default parameters
// (TS=5, TL=15, DEB=4). Each stimulus cycle pushes the expected {TS,TL,C}
// seen after the following rising edge; a monitor pops and compares one
// entry after every rising edge of Clk or reset.
// -----------------------------------------------------------------------------
module tb_traffic_timer;

    logic Clk    = 1'b0;
    logic reset  = 1'b0;
    logic ST     = 1'b0;
    logic CAR_IN = 1'b0;
    logic TS;
    logic TL;
    logic C;

    typedef struct {
        logic [2:0] exp;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 Clk = ~Clk;

    traffic_timer #(
        .TS_CYCLES  (5),
        .TL_CYCLES  (15),
        .DEB_CYCLES (4),
        .CNT_W      (16)
    ) dut (
        .Clk    (Clk),
        .reset  (reset),
        .ST     (ST),
        .CAR_IN (CAR_IN),
        .TS     (TS),
        .TL     (TL),
        .C      (C)
    );

    // Expected {TS,TL,C} k edges after an ST edge (or reset release).
    function automatic logic [2:0] tmr(input int k, input logic c);
        return {(k >= 5), (k >= 15), c};
    endfunction

    // One stimulus cycle: drive at the falling edge, expectation is for the
    // state after the next rising edge.
    task automatic step(input logic rst, input logic st, input logic car,
                        input logic [2:0] exp, input string tag);
        @(negedge Clk);
        reset  = rst;
        ST     = st;
        CAR_IN = car;
        sb_q.push_back('{exp: exp, tag: tag});
    endtask

    // Raise reset between edges; outputs must clear before the next edge
    // and stay clear across the edge that follows.
    task automatic async_reset(input string tag);
        @(negedge Clk);
        #2;
        sb_q.push_back('{exp: 3'b000, tag: tag});
        sb_q.push_back('{exp: 3'b000, tag: {tag, "_hold"}});
        ST     = 1'b0;
        CAR_IN = 1'b0;
        reset  = 1'b1;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk or posedge reset);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if ({TS, TL, C} !== e.exp) begin
                    errors++;
                    $display("FAIL %s: {TS,TL,C} got %b expected %b at %0t",
                             e.tag, {TS, TL, C}, e.exp, $time);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        // Power-on reset
        async_reset("por");
        step(1'b1, 1'b0, 1'b0, 3'b000, "por_hold2");

        // A: release with a one-cycle ST pulse, then ST=0 for 35 edges
        step(1'b0, 1'b1, 1'b0, 3'b000, "a_start");
        for (int k = 1; k <= 35; k++)
            step(1'b0, 1'b0, 1'b0, tmr(k, 1'b0), "a_run");

        // B: restart at edge 3 while TS=0
        step(1'b0, 1'b1, 1'b0, 3'b000, "b_start");
        for (int k = 1; k <= 2; k++)
            step(1'b0, 1'b0, 1'b0, tmr(k, 1'b0), "b_pre");
        step(1'b0, 1'b1, 1'b0, 3'b000, "b_restart");
        for (int k = 1; k <= 16; k++)
            step(1'b0, 1'b0, 1'b0, tmr(k, 1'b0), "b_run");

        // B2: ST on the very edge TS would rise, then on the edge TL would rise
        step(1'b0, 1'b1, 1'b0, 3'b000, "b_start2");
        for (int k = 1; k <= 4; k++)
            step(1'b0, 1'b0, 1'b0, tmr(k, 1'b0), "b_pre_ts");
        step(1'b0, 1'b1, 1'b0, 3'b000, "b_st_vs_ts");
        for (int k = 1; k <= 14; k++)
            step(1'b0, 1'b0, 1'b0, tmr(k, 1'b0), "b_pre_tl");
        step(1'b0, 1'b1, 1'b0, 3'b000, "b_st_vs_tl");
        step(1'b0, 1'b0, 1'b0, tmr(1, 1'b0), "b_post_tl");

        // C: ST held for 10 cycles, then released
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b1, 1'b0, 3'b000, "c_hold");
        for (int k = 1; k <= 6; k++)
            step(1'b0, 1'b0, 1'b0, tmr(k, 1'b0), "c_release");

        // D: CAR_IN step with ST held (timer flags known 0). First capture
        // edge j=0, car_s high after j=1, PENDING counts 1..4 on j=2..5,
        // C flips on j=6.
        for (int j = 0; j <= 8; j++)
            step(1'b0, 1'b1, 1'b1, {2'b00, (j >= 6)}, "d_rise");
        for (int j = 0; j <= 8; j++)
            step(1'b0, 1'b1, 1'b0, {2'b00, (j < 6)}, "d_fall");

        // E: glitches of 1, 2 and 3 cycles separated by 5 zero cycles
        for (int len = 1; len <= 3; len++) begin
            for (int i = 0; i < len; i++)
                step(1'b0, 1'b1, 1'b1, 3'b000, "e_pulse");
            for (int i = 0; i < 5; i++)
                step(1'b0, 1'b1, 1'b0, 3'b000, "e_gap");
        end
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b1, 1'b0, 3'b000, "e_tail");

        // F: reach count=9 with TS=1 and C=1, then reset between edges
        step(1'b0, 1'b1, 1'b1, 3'b000, "f_start");
        for (int k = 1; k <= 9; k++)
            step(1'b0, 1'b0, 1'b1, tmr(k, (k >= 6)), "f_run");
        async_reset("f_async");
        for (int k = 1; k <= 6; k++)
            step(1'b0, 1'b0, 1'b0, tmr(k, 1'b0), "f_after");

        // Every pushed expectation must have been consumed
        @(negedge Clk);
        @(negedge Clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_timer.md
TRAFFIC_TIMER -- requirements
Module: traffic_timer

Interface
REQ-001 The module SHALL have parameter TS_CYCLES, default 5, meaning the number of Clk cycles after a timer start at which TS asserts.
REQ-002 The module SHALL have parameter TL_CYCLES, default 15, meaning the number of Clk cycles after a timer start at which TL asserts.
REQ-003 The module SHALL have parameter DEB_CYCLES, default 4, meaning the number of consecutive differing samples required before C changes.
REQ-004 The module SHALL have parameter CNT_W, default 16, meaning the width of the timer and debounce counters.
REQ-005 Clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 ST  input  1  start timer, from the light controller; synchronous to Clk.
REQ-008 CAR_IN  input  1  raw side-road car sensor; asynchronous and may bounce.
REQ-009 TS  output  1  short interval elapsed since the last ST; registered.
REQ-010 TL  output  1  long interval elapsed since the last ST; registered.
REQ-011 C  output  1  debounced car-present; registered.

Function
REQ-012 Legal parameters SHALL satisfy 1 <= TS_CYCLES < TL_CYCLES <= 2^CNT_W-1 and 1 <= DEB_CYCLES <= 2^CNT_W-1; other values are unsupported.
REQ-013 The timer count SHALL be cleared to 0 at every rising edge where ST=1, and TS and TL SHALL be 0 after that edge.
REQ-014 At each edge where ST=0, the count SHALL increment by 1 and saturate at TL_CYCLES; it SHALL never wrap.
REQ-015 TS SHALL be registered as (count_next >= TS_CYCLES), so TS first reads 1 exactly TS_CYCLES edges after the ST edge.
REQ-016 TL SHALL be registered as (count_next >= TL_CYCLES), so TL first reads 1 exactly TL_CYCLES edges after the ST edge.
REQ-017 Once asserted, TS and TL SHALL stay 1 until the next ST; TL=1 SHALL imply TS=1.
REQ-018 If ST is held at 1 for several cycles, the count SHALL stay 0 and TS and TL SHALL stay 0.
REQ-019 ST arriving in the same cycle that TS or TL would assert SHALL take priority, so the count goes to 0 and the outputs go to 0.
REQ-020 CAR_IN SHALL pass through a two-flop synchronizer, giving car_s with a 2-cycle latency.
REQ-021 The debouncer SHALL be an FSM with states STABLE and PENDING and a counter deb_cnt.
REQ-022 In STABLE with car_s == C, the debouncer SHALL stay in STABLE with deb_cnt=0.
REQ-023 In STABLE with car_s != C, the debouncer SHALL go to PENDING with deb_cnt=1.
REQ-024 In PENDING with car_s == C, the debouncer SHALL go to STABLE with deb_cnt=0, discarding the glitch.
REQ-025 In PENDING with car_s != C and deb_cnt == DEB_CYCLES, the debouncer SHALL invert C on that edge and go to STABLE with deb_cnt=0.
REQ-026 In PENDING with car_s != C and deb_cnt < DEB_CYCLES, the debouncer SHALL increment deb_cnt and stay in PENDING.
REQ-027 C SHALL change at most once per DEB_CYCLES+1 cycles.
REQ-028 The timer and the debouncer SHALL operate independently; neither SHALL read the other's state.

Reset
REQ-029 While reset=1, the count, TS, TL, C, both synchronizer flops and deb_cnt SHALL be 0, and the debouncer state SHALL be STABLE, asynchronously and regardless of Clk.
REQ-030 Reset asserted mid-interval or mid-debounce SHALL discard all progress.
REQ-031 After reset release, the count SHALL begin incrementing on the first edge unless ST=1.
REQ-032 With ST=0 throughout, TS SHALL read 1 after TS_CYCLES edges following reset release.

Structure
REQ-033 Default TS_CYCLES, TL_CYCLES, DEB_CYCLES and CNT_W values and the debouncer state encodings SHALL live in a shared package, traffic_pkg, shared with the light controller bench.
REQ-034 The synchronizer and debouncer SHALL be one sub-module, car_debounce (ports Clk, reset, CAR_IN, C; parameters DEB_CYCLES, CNT_W).
REQ-035 The timer SHALL be inline in traffic_timer.
REQ-036 No combinational path SHALL exist from any input to any output.

Verification
REQ-037 The bench SHALL apply reset, release it, pulse ST for one cycle, then hold ST=0; it SHALL check that TS=1 exactly 5 edges after the ST edge, TL=1 exactly 15 edges after, and both then stay 1 for 20 more cycles.
REQ-038 The bench SHALL pulse ST at edge 3, when TS=0, and check that the count restarts, TS=0 until 5 edges later, and TL=0 until 15 edges later.
REQ-039 The bench SHALL hold ST=1 for 10 cycles and check TS=TL=0 throughout, then check TS=1 at 5 edges after ST falls.
REQ-040 The bench SHALL drive CAR_IN 0->1 and hold it, and check that C=1 on the edge 2+4 cycles after the first synchronized sample of 1 (6 edges after the input change, in sync with Clk).
REQ-041 The bench SHALL drive CAR_IN with pulses of 1, 2 and 3 cycles separated by 5 cycles of 0, and check that C stays 0 throughout.
REQ-042 The bench SHALL assert reset asynchronously between edges at count=9 with TS=1 and C=1, and check that TS, TL and C go to 0 before the next edge and that TS reasserts 5 edges after release.
